mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 141 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide unit controller: fixed-latency mult/div with
// mthi/mtlo moves and front-end stall generation.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start, op[2:0]       issue strobe and operation
//                        (0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo)
//   rs_val, rt_val       operands A and B
//   md_use               decode-stage instruction touches HI/LO
//   busy, stall, done    status / hazard / commit pulse
//   hi, lo               architectural HI and LO registers
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        md_use,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DIV  = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [31:0]   a_q;
   logic [31:0]   b_q;
   logic          sgn_q;

   logic [63:0]   ax;
   logic [63:0]   bx;
   logic [63:0]   prod;
   logic          a_neg;
   logic          b_neg;
   logic [31:0]   ua;
   logic [31:0]   ub;
   logic [31:0]   uq;
   logic [31:0]   ur;
   logic [31:0]   quo;
   logic [31:0]   rem;

   // Only the low 64 bits of the product are needed, so a plain
   // unsigned multiply of the sign/zero-extended operands suffices.
   always_comb begin
      ax   = {{32{sgn_q & a_q[31]}}, a_q};
      bx   = {{32{sgn_q & b_q[31]}}, b_q};
      prod = ax * bx;
   end

   // Division on magnitudes keeps everything 32-bit and makes the
   // 0x80000000 / -1 case fall out naturally (magnitude 2^31 fits).
   always_comb begin
      a_neg = sgn_q & a_q[31];
      b_neg = sgn_q & b_q[31];
      ua    = a_neg ? (~a_q + 32'd1) : a_q;
      ub    = b_neg ? (~b_q + 32'd1) : b_q;
      uq    = '0;
      ur    = '0;
      if (ub != 32'd0) begin
         uq = ua / ub;
         ur = ua % ub;
      end
      quo = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
      rem = a_neg ? (~ur + 32'd1) : ur;
   end

   assign busy  = (state != IDLE);
   assign stall = md_use & (busy | (start & ~op[2]));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  unique case (op)
                     3'd0, 3'd1: begin
                        state <= MUL;
                        cnt   <= CW'(MULT_CYCLES);
                        a_q   <= rs_val;
                        b_q   <= rt_val;
                        sgn_q <= ~op[0];
                     end
                     3'd2, 3'd3: begin
                        state <= DIV;
                        cnt   <= CW'(DIV_CYCLES);
                        a_q   <= rs_val;
                        b_q   <= rt_val;
                        sgn_q <= ~op[0];
                     end
                     3'd4: hi <= rs_val;
                     3'd5: lo <= rs_val;
                     default: ;
                  endcase
               end
            end
            MUL, DIV: begin
               if (cnt == CW'(1)) begin
                  state <= IDLE;
                  cnt   <= '0;
                  done  <= 1'b1;
                  if (state == MUL) begin
                     hi <= prod[63:32];
                     lo <= prod[31:0];
                  end else if (b_q != 32'd0) begin
                     hi <= rem;
                     lo <= quo;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus random
// operations compared against a 64-bit arithmetic reference model.
module tb_mdu_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        md_use;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .md_use(md_use),
      .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: architectural result of one op from the current model state.
   task automatic model(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int n,
                        output logic [31:0] eh, output logic [31:0] el);
      longint p;
      longint q;
      longint r;
      int sa;
      int sb;
      sa = a;
      sb = b;
      eh = hi_m;
      el = lo_m;
      n  = 0;
      case (o)
         3'd0: begin
            p = longint'(sa) * longint'(sb);
            {eh, el} = p;
            n = MC;
         end
         3'd1: begin
            p = longint'({32'd0, a}) * longint'({32'd0, b});
            {eh, el} = p;
            n = MC;
         end
         3'd2: begin
            n = DC;
            if (b != 0) begin
               q = longint'(sa) / longint'(sb);
               r = longint'(sa) % longint'(sb);
               el = q[31:0];
               eh = r[31:0];
            end
         end
         3'd3: begin
            n = DC;
            if (b != 0) begin
               q = longint'({32'd0, a}) / longint'({32'd0, b});
               r = longint'({32'd0, a}) % longint'({32'd0, b});
               el = q[31:0];
               eh = r[31:0];
            end
         end
         3'd4: eh = a;
         3'd5: el = a;
         default: ;
      endcase
   endtask

   // Called at a negedge; returns at the negedge of the done cycle
   // (or one cycle after issue for non-busy ops).
   task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
      int n;
      logic [31:0] eh;
      logic [31:0] el;
      model(o, a, b, n, eh, el);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      #1;
      chk("stall_issue", 32'(stall), 32'(md_use & (o < 3'd4)));
      @(negedge clk);
      start  = 1'b0;
      op     = 3'($urandom);
      rs_val = $urandom;
      rt_val = $urandom;
      if (n == 0) begin
         chk("busy_nb", 32'(busy), 32'd0);
         chk("done_nb", 32'(done), 32'd0);
         chk("hi_nb", hi, eh);
         chk("lo_nb", lo, el);
         hi_m = eh;
         lo_m = el;
      end else begin
         for (int i = 0; i < n; i++) begin
            chk("busy", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            chk("stall_busy", 32'(stall), 32'(md_use));
            chk("hi_hold", hi, hi_m);
            chk("lo_hold", lo, lo_m);
            if (poke && i == 1) begin
               start  = 1'b1;
               op     = 3'($urandom_range(0, 5));
               rs_val = $urandom;
               rt_val = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
         end
         chk("busy_end", 32'(busy), 32'd0);
         chk("done", 32'(done), 32'd1);
         chk("hi", hi, eh);
         chk("lo", lo, el);
         hi_m = eh;
         lo_m = el;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      op      = '0;
      rs_val  = '0;
      rt_val  = '0;
      md_use  = 1'b0;
      #3;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      md_use = 1'b1;
      start  = 1'b1;
      op     = 3'd1;
      #1;
      chk("rst_stall_md", 32'(stall), 32'd1);
      op = 3'd5;
      #1;
      chk("rst_stall_mv", 32'(stall), 32'd0);
      start  = 1'b0;
      md_use = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFA);
      run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
      chk("multu_hi", hi, 32'h0000_0002);
      chk("multu_lo", lo, 32'hFFFF_FFFA);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("ovf_hi", hi, 32'h0);
      chk("ovf_lo", lo, 32'h8000_0000);

      run_op(3'd4, 32'h11, 32'h0, 1'b0);
      run_op(3'd5, 32'h22, 32'h0, 1'b0);
      run_op(3'd3, 32'd5, 32'd0, 1'b0);
      chk("dz_hi", hi, 32'h11);
      chk("dz_lo", lo, 32'h22);

      md_use = 1'b1;
      run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      run_op(3'd5, 32'h5, 32'h0, 1'b0);
      chk("hz_lo", lo, 32'h5);
      md_use = 1'b0;

      start  = 1'b1;
      op     = 3'd2;
      rs_val = 32'd100;
      rt_val = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_hi", hi, 32'd0);
      chk("ab_lo", lo, 32'd0);
      hi_m = '0;
      lo_m = '0;
      repeat (DC) begin
         @(negedge clk);
         chk("ab_done", 32'(done), 32'd0);
      end
      reset_n = 1'b1;
      run_op(3'd0, 32'd2, 32'd3, 1'b0);
      chk("ab_mult_lo", lo, 32'd6);

      for (int k = 0; k < 40; k++) begin
         logic [2:0]  ro;
         logic [31:0] ra;
         logic [31:0] rb;
         ro = 3'($urandom);
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb & 32'hF;
         md_use = 1'($urandom);
         run_op(ro, ra, rb, 1'($urandom));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
